adc_slave_model: RTL and testbench

//  Synthesizable AD79X8-family SPI converter model (the device end of the serial link). Samples the host's
//  CS/SCLK/DIN on the system clock, shifts out a 16-bit conversion frame, and captures the 12-bit control word.

---
 rtl/adc_slave_model_pkg.sv | 51 +++++
 rtl/adc_slave_model_sync_edge.sv | 46 ++++
 rtl/adc_slave_model.sv | 192 +++++++++++++++++++
 tb/tb_adc_slave_model.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_slave_model_pkg.sv
// -----------------------------------------------------------------------------
// adc_slave_model_pkg
// Shared definitions for the AD79X8-family SPI converter model: frame and
// control-word sizes, control register bit positions, the control register
// layout as a packed struct, the device FSM state type and the sequencer
// channel-advance helper.
// -----------------------------------------------------------------------------
package adc_slave_model_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CTRL_BITS  = 12;
    localparam int NUM_CH     = 8;

    // Control register bit positions
    localparam int CTRL_WRITE   = 11;
    localparam int CTRL_SEQ     = 10;
    localparam int CTRL_ADD_HI  = 8;
    localparam int CTRL_ADD_LO  = 6;
    localparam int CTRL_PM_HI   = 5;
    localparam int CTRL_PM_LO   = 4;
    localparam int CTRL_SHADOW  = 3;
    localparam int CTRL_RANGE   = 1;
    localparam int CTRL_CODING  = 0;

    // Same layout as the bit positions above, MSB first.
    typedef struct packed {
        logic       write;
        logic       seq;
        logic       rsvd9;
        logic [2:0] add;
        logic [1:0] pm;
        logic       shadow;
        logic       rsvd2;
        logic       range_sel;
        logic       coding;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } adc_state_e;

    // Next channel of a running sequence: count up and wrap to 0 once the
    // limit is reached. ">=" rather than "==" so a channel left above the
    // limit by an earlier SEQ=0 write still returns to 0 promptly.
    function automatic logic [2:0] next_seq_ch(input logic [2:0] ch,
                                               input logic [2:0] limit);
        return (ch >= limit) ? 3'd0 : ch + 3'd1;
    endfunction

endpackage

// File: rtl/adc_slave_model_sync_edge.sv
// -----------------------------------------------------------------------------
// adc_sync_edge
// Multi-flop synchronizer for one asynchronous pin, followed by a rise/fall
// edge detector working on the synchronized level.
//
// Ports
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   d      in   raw pin
//   q      out  synchronized level
//   rise   out  one-clk pulse on a synchronized 0->1 transition
//   fall   out  one-clk pulse on a synchronized 1->0 transition
//
// INIT is the idle level of the pin. Resetting the chain to that level keeps
// a pin sitting at idle during reset release from looking like an edge.
// -----------------------------------------------------------------------------
module adc_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_sr;
    logic                   q_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_sr <= {SYNC_STAGES{INIT}};
            q_d     <= INIT;
        end else begin
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], d};
            q_d     <= sync_sr[SYNC_STAGES-1];
        end
    end

    assign q    = sync_sr[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/adc_slave_model.sv
// -----------------------------------------------------------------------------
// adc_slave_model
// Synthesizable device-side model of an AD7908/AD7918/AD7928 SPI converter.
// Oversamples the host's cs/sclk/din on clk, shifts out a 16-bit conversion
// frame {0, channel[2:0], sample[11:0]} MSB first, and captures the 12-bit
// control word clocked in on the first 12 sclk rises. Channel samples come
// from a parallel bus, so the block is a loopback target for a host design.
//
// Parameters
//   DIGITS       converter resolution: 8, 10 or 12
//   SYNC_STAGES  synchronizer depth on cs/sclk/din (>= 2)
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   cs          in   chip select, active low
//   sclk        in   serial clock, idle low
//   din         in   serial control data, MSB first
//   ch_data     in   channel n sample at [n*DIGITS +: DIGITS]
//   dout        out  serial conversion data, MSB first
//   dout_en     out  high while a frame is active
//   ctrl        out  control register
//   cur_ch      out  channel converted in the current or next frame
//   frame_done  out  one-clk pulse when a complete frame ends
//
// State table
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | cs high; waiting for cs falling edge, dout_en low
//   ST_SHIFT | frame active; sclk rises capture din, sclk falls advance dout
// -----------------------------------------------------------------------------
module adc_slave_model
    import adc_slave_model_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cs,
    input  logic                       sclk,
    input  logic                       din,
    input  logic [NUM_CH*DIGITS-1:0]   ch_data,
    output logic                       dout,
    output logic                       dout_en,
    output logic [CTRL_BITS-1:0]       ctrl,
    output logic [2:0]                 cur_ch,
    output logic                       frame_done
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_CTRL = 5'(CTRL_BITS);

    // Synchronized pins and edge pulses
    logic cs_lvl_unused, cs_rise, cs_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic din_s, din_rise_unused, din_fall_unused;

    adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .d     (cs),
        .q     (cs_lvl_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .d     (sclk),
        .q     (sclk_lvl_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_din (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (din_s),
        .rise  (din_rise_unused),
        .fall  (din_fall_unused)
    );

    adc_state_e             state;
    logic [4:0]             bit_cnt;
    // Frame bits 14..0 only; bit 15 is always 0 and goes straight to dout.
    logic [FRAME_BITS-2:0]  tx_sr;
    logic [CTRL_BITS-1:0]   rx_sr;
    logic [2:0]             seq_limit;

    logic [DIGITS-1:0]      ch_sel;
    logic [CTRL_BITS-1:0]   sample_aligned;
    logic                   write_req;
    ctrl_t                  ctrl_next;
    logic [2:0]             ch_next;
    logic [2:0]             limit_next;

    // Sample for the channel about to be converted, MSB-aligned in 12 bits.
    assign ch_sel         = ch_data[int'(cur_ch)*DIGITS +: DIGITS];
    assign sample_aligned = CTRL_BITS'(ch_sel) << (CTRL_BITS - DIGITS);

    // Register and channel update applied when a complete frame ends.
    // Mode decisions use the control word as it will be after the update.
    always_comb begin
        write_req  = rx_sr[CTRL_WRITE];
        ctrl_next  = write_req ? ctrl_t'(rx_sr) : ctrl_t'(ctrl);
        ch_next    = cur_ch;
        limit_next = seq_limit;
        if (!ctrl_next.seq) begin
            // Plain addressing; SEQ=0/SHADOW=1 behaves the same here.
            ch_next = ctrl_next.add;
        end else if (write_req && ctrl_next.shadow) begin
            // Start a new 0..ADD sequence.
            ch_next    = 3'd0;
            limit_next = ctrl_next.add;
        end else begin
            ch_next = next_seq_ch(cur_ch, seq_limit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            seq_limit  <= '0;
            dout       <= 1'b0;
            dout_en    <= 1'b0;
            ctrl       <= '0;
            cur_ch     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state   <= ST_SHIFT;
                        tx_sr   <= {cur_ch, sample_aligned};
                        dout    <= 1'b0;
                        dout_en <= 1'b1;
                        // An sclk rise landing on the cs fall is rise 1.
                        if (sclk_rise) begin
                            bit_cnt <= 5'd1;
                            rx_sr   <= {{(CTRL_BITS-1){1'b0}}, din_s};
                        end else begin
                            bit_cnt <= 5'd0;
                            rx_sr   <= '0;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (cs_rise) begin
                        state   <= ST_IDLE;
                        dout    <= 1'b0;
                        dout_en <= 1'b0;
                        bit_cnt <= '0;
                        // Short frames are discarded entirely.
                        if (bit_cnt == CNT_FULL) begin
                            frame_done <= 1'b1;
                            ctrl       <= ctrl_next;
                            cur_ch     <= ch_next;
                            seq_limit  <= limit_next;
                        end
                    end else begin
                        if (sclk_rise) begin
                            if (bit_cnt < CNT_CTRL) begin
                                rx_sr <= {rx_sr[CTRL_BITS-2:0], din_s};
                            end
                            if (bit_cnt < CNT_FULL) begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        // Zeros fill in behind, so dout stays 0 past bit 0.
                        if (sclk_fall) begin
                            dout  <= tx_sr[FRAME_BITS-2];
                            tx_sr <= {tx_sr[FRAME_BITS-3:0], 1'b0};
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_slave_model.sv
module tb_adc_slave_model;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b1;
    logic        sclk = 1'b0;
    logic        din = 1'b0;
    logic [7:0]  ch8 [8];
    logic [11:0] ch12 [8];
    logic [63:0] ch_bus8;
    logic [95:0] ch_bus12;

    logic        dout8, dout_en8, fd8;
    logic [11:0] ctrl8;
    logic [2:0]  cur8;
    logic        dout12, dout_en12, fd12;
    logic [11:0] ctrl12;
    logic [2:0]  cur12;

    int total = 0;
    int bad = 0;
    int fd8_cnt = 0;
    int fd12_cnt = 0;

    // reference model state
    logic [11:0] m_ctrl;
    logic [2:0]  m_cur, m_lim;

    always #5 clk = ~clk;

    always_comb begin
        ch_bus8  = '0;
        ch_bus12 = '0;
        for (int i = 0; i < 8; i++) begin
            ch_bus8[i*8 +: 8]   = ch8[i];
            ch_bus12[i*12 +: 12] = ch12[i];
        end
    end

    always @(negedge clk) begin
        if (fd8)  fd8_cnt  <= fd8_cnt + 1;
        if (fd12) fd12_cnt <= fd12_cnt + 1;
    end

    adc_slave_model #(.DIGITS(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .din(din),
        .ch_data(ch_bus8), .dout(dout8), .dout_en(dout_en8),
        .ctrl(ctrl8), .cur_ch(cur8), .frame_done(fd8)
    );

    adc_slave_model #(.DIGITS(12), .SYNC_STAGES(2)) dut12 (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .din(din),
        .ch_data(ch_bus12), .dout(dout12), .dout_en(dout_en12),
        .ctrl(ctrl12), .cur_ch(cur12), .frame_done(fd12)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Host side of one frame: 4-clk sclk phases, dout sampled at the end of
    // each high phase, din changed only while sclk is low.
    task automatic run_frame(input logic [11:0] word, input int nsclk, input bit coincident,
                             output logic [15:0] r8, output logic [15:0] r12,
                             output bit extra, output bit en_seen);
        r8 = '0; r12 = '0; extra = 1'b0; en_seen = 1'b0;
        if (coincident) begin
            for (int k = 0; k < 5; k++) begin
                din = 1'($urandom); sclk = 1'b1; wait_clk(4);
                sclk = 1'b0; wait_clk(4);
            end
            chk("idle_toggle.bitcnt8", 32'(dut8.bit_cnt), 0);
            chk("idle_toggle.dout_en12", 32'(dout_en12), 0);
            din = word[11]; cs = 1'b0; sclk = 1'b1;
            wait_clk(3);
            chk("coincident.bitcnt8", 32'(dut8.bit_cnt), 1);
            chk("coincident.bitcnt12", 32'(dut12.bit_cnt), 1);
            wait_clk(1);
        end else begin
            din = word[11]; cs = 1'b0; wait_clk(4);
            sclk = 1'b1; wait_clk(4);
        end
        for (int i = 0; i < nsclk; i++) begin
            if (i < 16) begin
                r8[15-i]  = dout8;
                r12[15-i] = dout12;
            end else begin
                extra = extra | dout8 | dout12;
            end
            if (i == 0) en_seen = dout_en8 & dout_en12;
            sclk = 1'b0;
            din = (i + 1 < 12) ? word[10-i] : 1'($urandom);
            if (i + 1 < nsclk) begin
                wait_clk(4); sclk = 1'b1; wait_clk(4);
            end
        end
        wait_clk(4);
        cs = 1'b1;
        wait_clk(6);
    endtask

    task automatic do_frame(input string tag, input logic [11:0] word, input int nsclk,
                            input bit coincident, input logic [15:0] e8, input logic [15:0] e12,
                            input logic edone, input logic [11:0] ectrl, input logic [2:0] ecur);
        logic [15:0] r8, r12, m;
        bit extra, en_seen;
        int f8, f12, n;
        f8 = fd8_cnt; f12 = fd12_cnt;
        run_frame(word, nsclk, coincident, r8, r12, extra, en_seen);
        n = (nsclk < 16) ? nsclk : 16;
        m = 16'hFFFF;
        m = m << (16 - n);
        chk({tag, ".dout8"}, 32'(r8 & m), 32'(e8 & m));
        chk({tag, ".dout12"}, 32'(r12 & m), 32'(e12 & m));
        if (nsclk > 16) chk({tag, ".dout_tail"}, 32'(extra), 0);
        chk({tag, ".dout_en_active"}, 32'(en_seen), 1);
        chk({tag, ".frame_done8"}, 32'(fd8_cnt - f8), 32'(edone));
        chk({tag, ".frame_done12"}, 32'(fd12_cnt - f12), 32'(edone));
        chk({tag, ".ctrl8"}, 32'(ctrl8), 32'(ectrl));
        chk({tag, ".ctrl12"}, 32'(ctrl12), 32'(ectrl));
        chk({tag, ".cur_ch8"}, 32'(cur8), 32'(ecur));
        chk({tag, ".cur_ch12"}, 32'(cur12), 32'(ecur));
        chk({tag, ".dout_en_idle"}, 32'({dout_en8, dout_en12, dout8, dout12}), 0);
    endtask

    // Behavioural model: expected frame contents and register effects.
    task automatic model_frame(input logic [11:0] w, input int n,
                               output logic [15:0] e8, output logic [15:0] e12, output logic ed);
        int cur;
        cur = int'(m_cur);
        e8  = 16'((cur << 12) | (int'(ch8[cur]) << 4));
        e12 = 16'((cur << 12) | int'(ch12[cur]));
        ed  = (n >= 16);
        if (ed) begin
            if (w[11]) m_ctrl = w;
            if (m_ctrl[10] == 1'b0) begin
                m_cur = m_ctrl[8:6];
            end else if (w[11] && m_ctrl[3]) begin
                m_cur = 3'd0;
                m_lim = m_ctrl[8:6];
            end else begin
                m_cur = (cur >= int'(m_lim)) ? 3'd0 : 3'(cur + 1);
            end
        end
    endtask

    typedef struct {
        logic [11:0] word;
        int          nsclk;
        logic        exp_done;
        logic [15:0] exp_d8;
        logic [15:0] exp_d12;
        logic [11:0] exp_ctrl;
        logic [2:0]  exp_cur;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e8, e12;
        logic        ed;
        logic [11:0] w;
        int          n;

        ch8  = '{8'h12, 8'h34, 8'h56, 8'hA5, 8'h78, 8'h9C, 8'hE1, 8'h0F};
        ch12 = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'hFFF, 12'h001, 12'h800};

        // word, nsclk, done, dout8, dout12, ctrl after, cur_ch after
        tbl[0]  = '{12'h8F0, 16, 1'b1, 16'h59C0, 16'h5FFF, 12'h8F0, 3'd3};
        tbl[1]  = '{12'h000, 16, 1'b1, 16'h3A50, 16'h3ABC, 12'h8F0, 3'd3};
        tbl[2]  = '{12'hC88, 16, 1'b1, 16'h3A50, 16'h3ABC, 12'hC88, 3'd0};
        tbl[3]  = '{12'h000, 16, 1'b1, 16'h0120, 16'h0123, 12'hC88, 3'd1};
        tbl[4]  = '{12'h000, 16, 1'b1, 16'h1340, 16'h1456, 12'hC88, 3'd2};
        tbl[5]  = '{12'h000, 16, 1'b1, 16'h2560, 16'h2789, 12'hC88, 3'd0};
        tbl[6]  = '{12'h000, 16, 1'b1, 16'h0120, 16'h0123, 12'hC88, 3'd1};
        tbl[7]  = '{12'h000, 16, 1'b1, 16'h1340, 16'h1456, 12'hC88, 3'd2};
        tbl[8]  = '{12'h800, 10, 1'b0, 16'h2560, 16'h2789, 12'hC88, 3'd2};
        tbl[9]  = '{12'h000, 16, 1'b1, 16'h2560, 16'h2789, 12'hC88, 3'd0};
        tbl[10] = '{12'h940, 16, 1'b1, 16'h0120, 16'h0123, 12'h940, 3'd5};
        tbl[11] = '{12'h000, 20, 1'b1, 16'h59C0, 16'h5FFF, 12'h940, 3'd5};

        wait_clk(4);
        reset = 1'b0;
        wait_clk(3);
        chk("reset.state", 32'({dout8, dout_en8, fd8, dout12, dout_en12, fd12}), 0);
        chk("reset.ctrl8", 32'(ctrl8), 0);
        chk("reset.ctrl12", 32'(ctrl12), 0);
        chk("reset.cur_ch", 32'({cur8, cur12}), 0);

        // idle sclk toggles, then cs fall on the same clk as an sclk rise
        do_frame("coincident", 12'h940, 16, 1'b1, 16'h0120, 16'h0123, 1'b1, 12'h940, 3'd5);

        for (int v = 0; v < 12; v++) begin
            do_frame($sformatf("vec%0d", v), tbl[v].word, tbl[v].nsclk, 1'b0,
                     tbl[v].exp_d8, tbl[v].exp_d12, tbl[v].exp_done,
                     tbl[v].exp_ctrl, tbl[v].exp_cur);
        end

        // reset in the middle of a frame after 7 sclk
        din = 1'b1; cs = 1'b0; wait_clk(4);
        for (int i = 0; i < 7; i++) begin
            sclk = 1'b1; wait_clk(4);
            sclk = 1'b0; din = 1'($urandom); wait_clk(4);
        end
        reset = 1'b1;
        #1;
        chk("midreset.outs", 32'({dout8, dout_en8, fd8, dout12, dout_en12, fd12}), 0);
        chk("midreset.ctrl8", 32'(ctrl8), 0);
        chk("midreset.ctrl12", 32'(ctrl12), 0);
        chk("midreset.cur_ch", 32'({cur8, cur12}), 0);
        chk("midreset.bitcnt", 32'({dut8.bit_cnt, dut12.bit_cnt}), 0);
        cs = 1'b1; din = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(3);
        m_ctrl = '0; m_cur = '0; m_lim = '0;
        model_frame(12'h000, 16, e8, e12, ed);
        do_frame("after_reset", 12'h000, 16, 1'b0, e8, e12, ed, m_ctrl, m_cur);

        // randomized frames against the model
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 8; c++) begin
                ch8[c]  = 8'($urandom);
                ch12[c] = 12'($urandom);
            end
            w = 12'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 20)) : 16;
            model_frame(w, n, e8, e12, ed);
            do_frame($sformatf("rand%0d", r), w, n, 1'b0, e8, e12, ed, m_ctrl, m_cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
